// File: rtl/led_pkg.sv
// Shared types and constants for the front-panel LED scheduler.
package led_pkg;

  localparam int N_REQ = 4;
  localparam int LED_W = 16;

  localparam logic [LED_W-1:0] ALARM_ON  = 16'hFFFF;
  localparam logic [LED_W-1:0] ALARM_OFF = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    return 4'(1) << idx;
  endfunction

  function automatic logic [LED_W-1:0] pat_sel(input logic [N_REQ*LED_W-1:0] pat,
                                               input logic [1:0] idx);
    case (idx)
      2'd0:    return pat[15:0];
      2'd1:    return pat[31:16];
      2'd2:    return pat[47:32];
      default: return pat[63:48];
    endcase
  endfunction

endpackage

// File: rtl/led_req_picker.sv
// Combinational owner pick: lowest index (mode 0) or first after last, wrapping (mode 1).
module led_req_picker
  import led_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  input  logic             mode,
  input  logic [N_REQ-1:0] excl,
  output logic             valid,
  output logic [1:0]       idx
);

  logic [N_REQ-1:0] cand;
  logic [1:0]       probe;

  always_comb begin
    cand  = req & ~excl;
    valid = |cand;
    idx   = '0;
    probe = '0;
    if (!mode) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (cand[i]) idx = 2'(i);
      end
    end else begin
      // Scan last+4 (== last) down to last+1 so the nearest candidate after last wins.
      for (int k = N_REQ; k >= 1; k--) begin
        probe = last + 2'(k);
        if (cand[probe]) idx = probe;
      end
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// Shares the 16-LED bank between four requesters with min-hold, rotation and alarm blink.
module led_scheduler
  import led_pkg::*;
#(
  parameter int DWELL      = 40_000_000,
  parameter int MIN_HOLD   = 4_000_000,
  parameter int ALARM_HALF = 5_000_000,
  parameter int CNT_W      = 26
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   mode,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LED_W-1:0] pat,
  input  logic                   alarm,
  output logic [LED_W-1:0]       led_out,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] HOLD_MIN  = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] BLINK_MAX = CNT_W'(ALARM_HALF - 1);

  state_t           state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [1:0]       last, last_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic [CNT_W-1:0] blink_cnt, blink_nxt;
  logic [LED_W-1:0] led_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [N_REQ-1:0] excl;
  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic             higher_req;
  logic             release_now;

  assign higher_req  = |(req & (onehot(owner) - 4'd1));
  assign release_now = (state == ST_SHOW) && (dwell_cnt >= HOLD_MIN) &&
                       (!req[owner] || (!mode && higher_req) ||
                        (mode && dwell_cnt == DWELL_MAX));
  assign excl = (state == ST_SHOW && !req[owner]) ? onehot(owner) : '0;

  led_req_picker u_picker (
    .req   (req),
    .last  (last),
    .mode  (mode),
    .excl  (excl),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    dwell_nxt = dwell_cnt;
    blink_nxt = blink_cnt;
    led_nxt   = ALARM_OFF;
    grant_nxt = '0;
    case (state)
      ST_IDLE, ST_SHOW: begin
        if (alarm) begin
          state_nxt = ST_ALARM;
          blink_nxt = '0;
          led_nxt   = ALARM_ON;
        end else if (state == ST_IDLE || release_now) begin
          if (pick_valid) begin
            state_nxt = ST_SHOW;
            owner_nxt = pick_idx;
            last_nxt  = pick_idx;
            dwell_nxt = '0;
            grant_nxt = onehot(pick_idx);
            led_nxt   = pat_sel(pat, pick_idx);
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          if (dwell_cnt != DWELL_MAX) dwell_nxt = dwell_cnt + 1'b1;
          grant_nxt = onehot(owner);
          led_nxt   = pat_sel(pat, owner);
        end
      end
      ST_ALARM: begin
        if (!alarm) begin
          state_nxt = ST_IDLE;
        end else if (blink_cnt == BLINK_MAX) begin
          blink_nxt = '0;
          led_nxt   = (led_out == ALARM_ON) ? ALARM_OFF : ALARM_ON;
        end else begin
          blink_nxt = blink_cnt + 1'b1;
          led_nxt   = led_out;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      last      <= 2'd3;
      dwell_cnt <= '0;
      blink_cnt <= '0;
      led_out   <= '0;
      grant     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      dwell_cnt <= dwell_nxt;
      blink_cnt <= blink_nxt;
      led_out   <= led_nxt;
      grant     <= grant_nxt;
      busy      <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_led_scheduler.sv
// Randomized and directed checks of led_scheduler against an owner/hold-time reference model.
module tb_led_scheduler;

  localparam int DWELL = 8;
  localparam int MIN_HOLD = 3;
  localparam int ALARM_HALF = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] pat = '0;
  logic        alarm = 1'b0;
  logic [15:0] led_out;
  logic [3:0]  grant;
  logic        busy;

  int n_checks = 0;
  int n_pass = 0;

  // reference model: owner index (-1 = none), cycles it has been on show so far
  int          m_owner, m_shown, m_last, m_alarm_n;
  bit          m_alarm;
  logic [15:0] e_led;
  logic [3:0]  e_grant;
  logic        e_busy;

  led_scheduler #(.DWELL(DWELL), .MIN_HOLD(MIN_HOLD), .ALARM_HALF(ALARM_HALF), .CNT_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mode    (mode),
    .req     (req),
    .pat     (pat),
    .alarm   (alarm),
    .led_out (led_out),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] r, input logic md, input int lst);
    if (!md) begin
      for (int i = 0; i < 4; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) if (r[(lst + k) % 4]) return (lst + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_shown = 0; m_last = 3; m_alarm = 0; m_alarm_n = 0;
    e_led = '0; e_grant = '0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    bit rel;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (alarm) begin
      if (!m_alarm) begin m_alarm = 1; m_alarm_n = 0; end
      else m_alarm_n++;
      m_owner = -1;
      e_led = (((m_alarm_n / ALARM_HALF) % 2) == 0) ? 16'hFFFF : 16'h0000;
      e_grant = '0; e_busy = 1'b1;
      return;
    end
    if (m_alarm) begin
      m_alarm = 0; m_owner = -1;
    end else if (m_owner < 0) begin
      if (req != 0) begin m_owner = pick(req, mode, m_last); m_last = m_owner; m_shown = 1; end
    end else begin
      rel = (m_shown >= MIN_HOLD) &&
            (!req[m_owner] || (!mode && ((req & ((4'd1 << m_owner) - 4'd1)) != 0)) ||
             (mode && m_shown >= DWELL));
      if (!rel) m_shown++;
      else if (req == 0) m_owner = -1;
      else begin m_owner = pick(req, mode, m_last); m_last = m_owner; m_shown = 1; end
    end
    e_grant = (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0;
    e_led   = (m_owner >= 0) ? pat[m_owner*16 +: 16] : 16'h0;
    e_busy  = (m_owner >= 0);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_eq("led", led_out, e_led);
    check_eq("grant", grant, e_grant);
    check_eq("busy", busy, e_busy);
  endtask

  initial begin
    bit got;
    model_reset();
    repeat (3) cycle();
    check_eq("rst_led", led_out, 0);
    check_eq("rst_grant", grant, 0);
    reset_n = 1'b1;
    repeat (3) cycle();
    check_eq("idle_busy", busy, 0);

    // rotation right after reset starts at index 0
    mode = 1'b1; req = 4'b1011;
    for (int i = 0; i < 25; i++) begin
      cycle();
      check_eq("rot_grant", grant, (i < 8) ? 4'b0001 : (i < 16) ? 4'b0010 : (i < 24) ? 4'b1000 : 4'b0001);
    end
    req = 4'b0010; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin cycle(); got = (grant == 4'b0010); end
    check_eq("single_reached", got, 1);
    repeat (20) begin cycle(); check_eq("single_steady", grant, 4'b0010); end

    req = '0; mode = 1'b0;
    repeat (12) cycle();

    // priority preempt honours the minimum hold
    pat = 64'h0000_00F0_0000_0000; req = 4'b0100;
    cycle();
    check_eq("pre_grant", grant, 4'b0100);
    check_eq("pre_led", led_out, 16'h00F0);
    req = 4'b0101; pat[15:0] = 16'hAAAA;
    cycle(); check_eq("pre_hold1", grant, 4'b0100);
    cycle(); check_eq("pre_hold2", grant, 4'b0100);
    cycle(); check_eq("pre_switch", grant, 4'b0001);
    check_eq("pre_led0", led_out, 16'hAAAA);

    req = '0;
    repeat (6) cycle();
    req = 4'b0010;
    cycle(); check_eq("drop_g1", grant, 4'b0010);
    req = '0;
    cycle(); check_eq("drop_g2", grant, 4'b0010);
    cycle(); check_eq("drop_g3", grant, 4'b0010);
    cycle(); check_eq("drop_idle", grant, 0);
    check_eq("drop_led", led_out, 0);

    req = 4'b0001;
    repeat (2) cycle();
    alarm = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      check_eq("alm_grant", grant, 0);
      check_eq("alm_led", led_out, (((k / 4) % 2) == 0) ? 16'hFFFF : 16'h0000);
    end
    alarm = 1'b0;
    cycle(); check_eq("alm_idle", busy, 0);
    cycle(); check_eq("alm_regrant", grant, 4'b0001);

    // async reset between edges while showing
    mode = 1'b1; req = 4'b1111;
    repeat (5) cycle();
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_eq("areset_led", led_out, 0);
    check_eq("areset_grant", grant, 0);
    check_eq("areset_busy", busy, 0);
    model_reset();
    @(negedge clock);
    repeat (2) cycle();
    reset_n = 1'b1;
    cycle();
    check_eq("areset_first", grant, 4'b0001);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 8 == 0) req = 4'($urandom);
      if ($urandom % 48 == 0) alarm = ~alarm;
      if ($urandom % 40 == 0) mode = ~mode;
      pat = {$urandom, $urandom};
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_scheduler.md
# led_scheduler

Controller that shares the 16-LED front-panel bank between up to four display requesters, such as the rate progress bar, the cylon pattern, the clock/link status word and a firmware-driven identify pattern. It arbitrates by fixed priority or by timed round-robin, enforces a minimum on-screen hold so every pattern stays readable, and overrides everything with an alarm blink. It sits between the LED pattern generators and the registered `led_out` pins, in the 40 MHz `clock` domain.

## Interface
- `DWELL`, 40_000_000: rotate-mode slot length in clocks (1 s); legal range ≥ `MIN_HOLD`.
- `MIN_HOLD`, 4_000_000: minimum clocks an owner is shown before preemption or release (100 ms); legal range ≥1.
- `ALARM_HALF`, 5_000_000: alarm blink half-period in clocks (4 Hz); legal range ≥1.
- `CNT_W`, 26: width of the dwell and blink counters; must hold `DWELL-1`.

Ports:
- `clock`  in  1: 40 MHz system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `mode`  in  1: selects arbitration. 0 = fixed priority (req[0] highest); 1 = round-robin rotate.
- `req`  in  4: per-requester display request, level-sensitive.
- `pat`  in  64: requester patterns; requester i drives `pat[16i+15:16i]`.
- `alarm`  in  1: level; forces blink override.
- `led_out`  out  16: registered LED drive.
- `grant`  out  4: registered, one-hot current owner; all zeros when there is no owner.
- `busy`  out  1: registered; high in SHOW or ALARM.

## Operation
The FSM has three states: IDLE, SHOW, ALARM. Reset puts it in IDLE with `led_out`=0, `grant`=0, `busy`=0, counters=0 and `last`=3.

IDLE:
- `led_out`=0.
- If `alarm`, go to ALARM.
- Otherwise, if any `req` bit is set, pick an owner and go to SHOW with `dwell_cnt`=0.

Owner pick:
- mode 0: the lowest asserted index.
- mode 1: the first asserted index after `last`, scanning upward and wrapping 3→0. `last` is included as the final candidate.
- After every pick, `last` is updated to the new owner.

SHOW:
- `led_out` follows `pat[owner]` live, registered one cycle behind.
- `dwell_cnt` increments and saturates at `DWELL-1`.
- The owner is released once `dwell_cnt ≥ MIN_HOLD-1` and any of the following holds:
  - `req[owner]`=0. Re-pick from the remaining requests; if none remain, go to IDLE.
  - mode 0 and a higher-priority `req` is asserted. Switch to it.
  - mode 1 and `dwell_cnt`=`DWELL-1`. Re-pick. If the owner is the only requester it is re-granted, `dwell_cnt` restarts and `grant` stays steady.
- Before `MIN_HOLD` is reached, the owner is held even if it drops `req`, and its live pattern is still shown.
- Any switch resets `dwell_cnt` to 0.

ALARM:
- Entered from any state the cycle after `alarm`=1; this beats MIN_HOLD.
- `grant`=0 and `busy`=1.
- `led_out` is 16'hFFFF for `ALARM_HALF` clocks, then 16'h0000 for `ALARM_HALF` clocks, repeating. The phase starts at all-ones on entry.
- When `alarm`=0, go to IDLE. `last` is preserved, so rotation resumes where it left off.

Other rules:
- A `mode` change is sampled only at pick/release decisions; it never aborts MIN_HOLD.
- Simultaneous owner release and higher-priority request: the new pick uses the current `req`, so the higher-priority requester wins.

## Timing
- Latency is 1 clock from input to output. `req` or `alarm` asserted in cycle t gives `grant`, `busy` and `led_out` updated at t+1.
- Pattern path: `pat` change in cycle t appears on `led_out` at t+1.
- Hold boundary: a grant at t+1 is preemptable at the earliest on a decision in cycle t+`MIN_HOLD`, so the new grant appears at t+1+`MIN_HOLD`.
- Rotate slot: each owner is shown for exactly `DWELL` clocks when others are requesting.
- Mid-operation reset: the async assert clears all outputs immediately. Deassertion is synchronized upstream.

## Structure
- Shared package `led_pkg`:
  - FSM state encoding (IDLE/SHOW/ALARM).
  - `N_REQ`=4 and `LED_W`=16.
  - Alarm on/off pattern constants.
- Sub-module `led_req_picker`, purely combinational:
  - Inputs: `req`, `last`, `mode`, and an exclude mask.
  - Outputs: a valid flag and a 2-bit index.
  - It is reused for both the initial pick and the re-pick.
- Counters and the FSM live in `led_scheduler`.

## Test plan
All scenarios use `DWELL`=8, `MIN_HOLD`=3, `ALARM_HALF`=4.

- **Reset/idle**: hold `reset_n`=0, then release with `req`=0 → `led_out`=0, `grant`=0, `busy`=0 for all cycles.
- **Priority preempt**: mode 0; `req`=4'b0100 at t0 with pat2=16'h00F0 → `grant`=0100 and `led_out`=00F0 at t0+1. At t0+1 raise req[0] with pat0=16'hAAAA → `grant`=0001 first at t0+4, not earlier.
- **Rotate**: mode 1; `req`=4'b1011 held → grants cycle 0001→0010→1000→0001, each exactly 8 clocks. Single requester req=4'b0010 → `grant` stays 0010 with no glitch.
- **Early drop**: mode 0; req[1] pulses for 1 clock → `grant`=0010 for exactly 3 clocks, then IDLE with `led_out`=0.
- **Alarm override**: pulse `alarm` for 20 clocks during SHOW → `grant`=0 next cycle; `led_out` reads FFFF×4, 0000×4, FFFF×4, 0000×4, FFFF×4; then IDLE and re-grant on the following cycle.
- **Async reset mid-SHOW**: drop `reset_n` between clock edges → outputs are 0 before the next edge, and the rotation pointer restarts so the first mode-1 pick is index 0.
